if_id_stage: RTL
================

Name: if_id_stage

Overview:
Fetch stage plus IF/ID pipeline register. It holds the program counter, selects the next PC, and forms PC+4. It drives the instruction-memory address and captures the fetched instruction, PC and PC+4 into the decode-stage register. Decode then feeds id_ex. Stall, flush and redirect inputs come from the hazard unit and from branch/jump resolution in EX.

Parameters:
WIDTH, 32, datapath/address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on reset/flush

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
StallF  input  1  hold PC (no advance)
StallD  input  1  hold IF/ID register contents
FlushD  input  1  replace IF/ID contents with bubble
PCSrc_E  input  1  taken branch/jump resolved in EX; redirect PC
PCTarget_E  input  WIDTH  redirect target from EX
Instr_F  input  WIDTH  instruction read combinationally from imem at PC_F
PC_F  output  WIDTH  current fetch PC, imem address
Instr_D  output  WIDTH  registered instruction to decode
PC_D  output  WIDTH  registered PC of Instr_D
PCP4_D  output  WIDTH  registered PC_F+4 of Instr_D
Valid_D  output  1  1 = Instr_D is a real fetched instruction, 0 = bubble

Behaviour:
- One clock, clk. Reset synchronous, active-high (rst); sampled only on a rising clk edge.
- Reset values: PC_F=RESET_PC, Instr_D=NOP_INSTR, PC_D=0, PCP4_D=0, Valid_D=0.
- Reset overrides every other input in the same cycle. Reset asserted mid-stream discards in-flight state.
- PC next-state priority, highest first:
  - rst
  - PCSrc_E: PC_F <= {PCTarget_E[WIDTH-1:2],2'b00}; low two bits always forced to 0.
  - !StallF: PC_F <= PC_F+4.
  - else hold.
- Redirect beats StallF: a taken branch in EX kills whatever caused the stall.
- PC+4 is modulo 2^WIDTH: 32'hFFFF_FFFC+4 = 32'h0000_0000, no trap.
- IF/ID next-state priority, highest first:
  - rst or FlushD: bubble (reset values above).
  - !StallD: Instr_D<=Instr_F, PC_D<=PC_F, PCP4_D<=PC_F+4, Valid_D<=1.
  - else hold all four.
- FlushD beats StallD.
- The block never flushes itself on PCSrc_E. The hazard unit drives FlushD (=PCSrc_E) explicitly.
- Latency: instruction at PC_F appears on Instr_D one cycle later when unstalled.
- StallF=1 with StallD=0 is legal and re-latches the same instruction. Valid_D stays 1.
- All outputs are registered. No combinational path from inputs to outputs except Instr_F's dependence on PC_F via external imem.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs StallCnt[31:0] and FlushCnt[31:0], both reset to 0.
  - StallCnt increments each cycle StallD=1 and FlushD=0.
  - FlushCnt increments each cycle FlushD=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: counters and ports are absent. Core behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - XLEN=32
  - NOP_INSTR constant
  - default RESET_PC
  - an if_id_t packed struct {instr, pc, pcp4, valid}, so the register is one struct flop.
- One natural sub-module: pc_reg, containing the PC flop, redirect/stall priority, alignment and the +4 adder. It outputs PC_F and PCPlus4_F.

Test Plan:
- Reset: rst high 2 cycles then low, Instr_F=32'h00500093 -> during reset PC_F=0, Valid_D=0, Instr_D=32'h13. First edge after release: Instr_D=32'h00500093, PC_D=0, PCP4_D=4, PC_F=4.
- Free run: 5 cycles no stall -> PC_F sequence 0,4,8,12,16, with PC_D trailing by one cycle.
- Stall: StallF=StallD=1 for 3 cycles at PC_F=8 -> PC_F stays 8. Instr_D/PC_D=4 held. Then resumes at 12.
- Redirect+flush: PCSrc_E=1, PCTarget_E=32'h103, FlushD=1, StallF=1 same cycle -> next PC_F=32'h100, Instr_D=32'h13, Valid_D=0.
- FlushD with StallD simultaneously -> bubble wins: Valid_D=0, PC_D=0.
- Wrap: force PC_F=32'hFFFF_FFFC via redirect, run one cycle -> PC_F=0, PCP4_D=0. With FETCH_PERF_CNT_EN, 3 stall cycles and 1 flush -> StallCnt=3, FlushCnt=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch/decode front end.
// Combinational definitions only, so no latency and no backpressure.
// The IF/ID register is one packed struct so it is a single flop.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 : canonical bubble instruction
  localparam logic [XLEN-1:0] NOP_INSTR_C      = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcp4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter: redirect/stall priority, word alignment and +4 adder.
// Latency: PC_F updates one clk after the inputs; PCPlus4_F is combinational from PC_F.
// Backpressure: StallF holds the PC; a redirect (PCSrc_E) overrides the stall.
module pc_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned           WIDTH    = XLEN,
  parameter logic [WIDTH-1:0]      RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             PCSrc_E,
  input  logic [WIDTH-1:0] PCTarget_E,
  output logic [WIDTH-1:0] PC_F,
  output logic [WIDTH-1:0] PCPlus4_F
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Sequential fetch wraps modulo 2^WIDTH; no trap on overflow.
  assign PCPlus4_F = pc_q + WIDTH'(4);
  assign PC_F      = pc_q;

  // Next PC: redirect beats stall, since the branch kills whatever caused the stall.
  always_comb begin
    pc_d = pc_q;
    if (PCSrc_E) begin
      pc_d = {PCTarget_E[WIDTH-1:2], 2'b00};
    end else if (!StallF) begin
      pc_d = PCPlus4_F;
    end
  end

  // PC flop with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID register; optional FETCH_PERF_CNT_EN adds stall/flush counters.
// Latency: the instruction at PC_F appears on Instr_D one clk later when unstalled.
// Backpressure: StallF holds PC, StallD holds IF/ID, FlushD inserts a bubble (beats StallD).
module if_id_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [WIDTH-1:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrc_E,
  input  logic [WIDTH-1:0] PCTarget_E,
  input  logic [WIDTH-1:0] Instr_F,
  output logic [WIDTH-1:0] PC_F,
  output logic [WIDTH-1:0] Instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PCP4_D,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]      StallCnt,
  output logic [31:0]      FlushCnt,
`endif
  output logic             Valid_D
);

  logic [WIDTH-1:0] pcp4_f;
  if_id_t           if_id_q;
  if_id_t           if_id_d;
  if_id_t           bubble;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .PCSrc_E    (PCSrc_E),
    .PCTarget_E (PCTarget_E),
    .PC_F       (PC_F),
    .PCPlus4_F  (pcp4_f)
  );

  assign bubble = '{instr: NOP_INSTR, pc: '0, pcp4: '0, valid: 1'b0};

  // IF/ID next state: flush beats stall; a redirect alone never flushes here.
  always_comb begin
    if_id_d = if_id_q;
    if (FlushD) begin
      if_id_d = bubble;
    end else if (!StallD) begin
      if_id_d = '{instr: Instr_F, pc: PC_F, pcp4: pcp4_f, valid: 1'b1};
    end
  end

  // IF/ID register; reset loads the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q <= bubble;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign Instr_D = if_id_q.instr;
  assign PC_D    = if_id_q.pc;
  assign PCP4_D  = if_id_q.pcp4;
  assign Valid_D = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating event counters; a flushed cycle is not counted as a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallD && !FlushD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (FlushD && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule
